// File: rtl/owl_avm_write_bridge_pkg.sv
// Shared types for the Avalon-MM burst write bridge.
package owl_avm_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

endpackage

// File: rtl/owl_avm_write_bridge_if.sv
// Engine-side burst-write bus and Avalon-MM burst write master bus.
interface owl_wbus_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int BL = 4
);
  logic          bus_wval;
  logic          bus_wrdy;
  logic [BL-1:0] bus_wlen;
  logic [AW-1:0] bus_waddr;
  logic [DW-1:0] bus_wdata;

  modport master (output bus_wval, bus_wlen, bus_waddr, bus_wdata, input bus_wrdy);
  modport slave  (input bus_wval, bus_wlen, bus_waddr, bus_wdata, output bus_wrdy);
endinterface

interface owl_avm_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int BL = 4
);
  logic            avm_write;
  logic [AW-1:0]   avm_address;
  logic [BL:0]     avm_burstcount;
  logic [DW-1:0]   avm_writedata;
  logic [DW/8-1:0] avm_byteenable;
  logic            avm_waitrequest;

  modport master (
    output avm_write, avm_address, avm_burstcount, avm_writedata, avm_byteenable,
    input  avm_waitrequest
  );
  modport slave (
    input  avm_write, avm_address, avm_burstcount, avm_writedata, avm_byteenable,
    output avm_waitrequest
  );
endinterface

// File: rtl/owl_avm_write_bridge_fifo.sv
// Show-ahead synchronous FIFO: rdata always presents the head entry.
module owl_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == DEPTH[AW:0]);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/owl_avm_write_bridge.sv
// Buffers each engine burst whole, then replays it as an Avalon-MM burst write
// so avm_write never drops mid-burst.
module owl_avm_write_bridge
  import owl_avm_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int BL      = 4,
  parameter int FIFO_AW = 5,
  parameter int CMD_AW  = 2
) (
  input  logic      clk,
  input  logic      rst,
  owl_wbus_if.slave bus,
  owl_avm_if.master avm,
  output logic      idle
);
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [BL-1:0] len;
  } cmd_t;

  if (FIFO_AW < BL) begin : g_fifo_depth_check
    $error("owl_avm_write_bridge: FIFO_AW must be >= BL so a whole burst fits");
  end

  logic [BL-1:0]    in_cnt_q;
  logic [BL-1:0]    in_len_q;
  logic [BL-1:0]    eff_len;
  logic             first_beat;
  logic             beat_acc;
  logic             data_full;
  logic             data_empty;
  logic [FIFO_AW:0] data_count;
  logic             cmd_full;
  logic             cmd_empty;
  logic [CMD_AW:0]  cmd_count;
  logic             cmd_pop;
  logic             data_pop;
  cmd_t             cmd_in;
  cmd_t             cmd_head;

  state_e           state_q;
  logic             avm_write_q;
  logic [AW-1:0]    avm_address_q;
  logic [BL:0]      avm_burstcount_q;
  logic [BL:0]      burstcount_d;
  logic [BL-1:0]    out_cnt_q;
  logic             start_burst;

  // Input side: only the first beat of a burst may push a command.
  assign first_beat    = (in_cnt_q == '0);
  assign eff_len       = first_beat ? bus.bus_wlen : in_len_q;
  assign bus.bus_wrdy  = !rst && !data_full && (!first_beat || !cmd_full);
  assign beat_acc      = bus.bus_wval && bus.bus_wrdy;
  assign cmd_in.addr   = bus.bus_waddr;
  assign cmd_in.len    = bus.bus_wlen;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt_q <= '0;
      in_len_q <= '0;
    end else if (beat_acc) begin
      if (first_beat) in_len_q <= bus.bus_wlen;
      in_cnt_q <= (in_cnt_q == eff_len) ? '0 : in_cnt_q + 1'b1;
    end
  end

  owl_sync_fifo #(.WIDTH(DW), .AW(FIFO_AW)) u_data_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (beat_acc),
    .wdata (bus.bus_wdata),
    .pop   (data_pop),
    .rdata (avm.avm_writedata),
    .full  (data_full),
    .empty (data_empty),
    .count (data_count)
  );

  owl_sync_fifo #(.WIDTH($bits(cmd_t)), .AW(CMD_AW)) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (beat_acc && first_beat),
    .wdata (cmd_in),
    .pop   (cmd_pop),
    .rdata (cmd_head),
    .full  (cmd_full),
    .empty (cmd_empty),
    .count (cmd_count)
  );

  // Widened by one bit so a max-length burst yields 2^BL without wrapping.
  assign burstcount_d = {1'b0, cmd_head.len} + {{BL{1'b0}}, 1'b1};
  assign start_burst  = (state_q == IDLE) && (cmd_count != '0) &&
                        (data_count >= (FIFO_AW+1)'(burstcount_d));
  assign cmd_pop      = start_burst;
  assign data_pop     = (state_q == BURST) && !avm.avm_waitrequest;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      avm_write_q      <= 1'b0;
      avm_address_q    <= '0;
      avm_burstcount_q <= '0;
      out_cnt_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_burst) begin
            avm_address_q    <= cmd_head.addr;
            avm_burstcount_q <= burstcount_d;
            out_cnt_q        <= cmd_head.len;
            avm_write_q      <= 1'b1;
            state_q          <= BURST;
          end
        end
        BURST: begin
          if (!avm.avm_waitrequest) begin
            if (out_cnt_q == '0) begin
              avm_write_q <= 1'b0;
              state_q     <= IDLE;
            end else begin
              out_cnt_q <= out_cnt_q - 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign avm.avm_write      = avm_write_q;
  assign avm.avm_address    = avm_address_q;
  assign avm.avm_burstcount = avm_burstcount_q;
  assign avm.avm_byteenable = '1;
  assign idle               = cmd_empty && data_empty && (state_q == IDLE);
endmodule

// File: tb/tb_owl_avm_write_bridge.sv
// Directed bench for owl_avm_write_bridge: one line per Avalon burst issued.
module tb_owl_avm_write_bridge;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int BL      = 4;
  localparam int FIFO_AW = 4;
  localparam int CMD_AW  = 2;
  localparam int QN      = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic idle;

  always #5 clk = ~clk;

  owl_wbus_if #(.AW(AW), .DW(DW), .BL(BL)) bus ();
  owl_avm_if  #(.AW(AW), .DW(DW), .BL(BL)) avm ();

  owl_avm_write_bridge #(
    .AW(AW), .DW(DW), .BL(BL), .FIFO_AW(FIFO_AW), .CMD_AW(CMD_AW)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .avm  (avm),
    .idle (idle)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_acc = 0;
  bit tx_done  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Beat monitor: samples after the test thread has driven waitrequest.
  int          mon_n    = 0;
  int          mon_beat = 0;
  int          q_cyc   [QN];
  logic [31:0] q_addr  [QN];
  logic [31:0] q_baddr [QN];
  logic [31:0] q_data  [QN];
  logic [4:0]  q_bc    [QN];

  always @(negedge clk) begin
    #1;
    if (rst) begin
      mon_beat = 0;
    end else if (avm.avm_write && !avm.avm_waitrequest && mon_n < QN) begin
      if (mon_beat == 0)
        $display("avm burst addr=0x%08h count=%0d cycle=%0d",
                 avm.avm_address, avm.avm_burstcount, cyc);
      q_cyc[mon_n]   = cyc;
      q_addr[mon_n]  = avm.avm_address;
      q_baddr[mon_n] = avm.avm_address + 32'(4 * mon_beat);
      q_data[mon_n]  = avm.avm_writedata;
      q_bc[mon_n]    = avm.avm_burstcount;
      mon_n++;
      mon_beat = (mon_beat + 1 >= int'(avm.avm_burstcount)) ? 0 : mon_beat + 1;
    end
  end

  task automatic send_beat(input logic [31:0] a, input logic [3:0] l, input logic [31:0] d);
    int t = 0;
    bus.bus_wval  = 1'b1;
    bus.bus_waddr = a;
    bus.bus_wlen  = l;
    bus.bus_wdata = d;
    #1;
    while (!bus.bus_wrdy && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) chk("wrdy_timeout", 64'(t), 0);
    last_acc = cyc + 1;
    @(negedge clk);
    bus.bus_wval = 1'b0;
  endtask

  task automatic wait_beats(input string tag, input int target, input int budget);
    int t = 0;
    while (mon_n < target && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 64'(mon_n >= target), 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog cycles=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int acc4;
    int t;
    int nb;
    int bad_bc;
    int idx;
    logic [31:0] exp_img [256];
    logic [31:0] got_img [256];

    bus.bus_wval        = 1'b0;
    bus.bus_wlen        = '0;
    bus.bus_waddr       = '0;
    bus.bus_wdata       = '0;
    avm.avm_waitrequest = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_wrdy_low", bus.bus_wrdy, 0);
    chk("rst_write_low", avm.avm_write, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_idle", idle, 1);
    chk("rst_wrdy_high", bus.bus_wrdy, 1);
    chk("rst_addr", avm.avm_address, 0);
    chk("rst_bc", avm.avm_burstcount, 0);
    chk("byteenable", avm.avm_byteenable, 4'hF);

    // 1: single 4-beat burst
    base = mon_n;
    for (int i = 0; i < 4; i++) send_beat(32'h100, 4'd3, 32'(i + 1));
    acc4 = last_acc;
    wait_beats("t1_beats", base + 4, 50);
    for (int i = 0; i < 4; i++) begin
      chk("t1_data", q_data[base+i], 64'(i + 1));
      chk("t1_addr", q_addr[base+i], 32'h100);
      chk("t1_bc", q_bc[base+i], 4);
      chk("t1_cycle", 64'(q_cyc[base+i]), 64'(acc4 + 1 + i));
    end
    chk("t1_write_low", avm.avm_write, 0);
    chk("t1_idle", idle, 1);

    // 2: waitrequest high for three cycles on beat 2
    base = mon_n;
    for (int i = 0; i < 4; i++) send_beat(32'h100, 4'd3, 32'(i + 1));
    t = 0;
    while (!avm.avm_write && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("t2_write_seen", avm.avm_write, 1);
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      avm.avm_waitrequest = (s < 3);
      chk("t2_hold_data", avm.avm_writedata, 2);
      chk("t2_hold_addr", avm.avm_address, 32'h100);
      chk("t2_hold_bc", avm.avm_burstcount, 4);
      @(negedge clk);
    end
    avm.avm_waitrequest = 1'b0;
    wait_beats("t2_beats", base + 4, 50);
    chk("t2_pops", 64'(mon_n - base), 4);
    for (int i = 0; i < 4; i++) chk("t2_data", q_data[base+i], 64'(i + 1));
    chk("t2_addr_after", avm.avm_address, 32'h100);

    // 3: eight back-to-back single-beat bursts
    base = mon_n;
    for (int i = 0; i < 8; i++) send_beat(32'h200 + 32'(4 * i), 4'd0, 32'hA0 + 32'(i));
    wait_beats("t3_beats", base + 8, 100);
    for (int i = 0; i < 8; i++) begin
      chk("t3_addr", q_addr[base+i], 32'h200 + 32'(4 * i));
      chk("t3_bc", q_bc[base+i], 1);
      chk("t3_data", q_data[base+i], 32'hA0 + 32'(i));
      if (i > 0) chk("t3_gap", 64'(q_cyc[base+i] - q_cyc[base+i-1]), 2);
    end

    // 4: full data FIFO with waitrequest held
    base = mon_n;
    avm.avm_waitrequest = 1'b1;
    for (int i = 0; i < 16; i++) send_beat(32'h400, 4'd15, 32'h1000 + 32'(i));
    chk("t4_wrdy_full", bus.bus_wrdy, 0);
    repeat (2) @(negedge clk);
    chk("t4_write_high", avm.avm_write, 1);
    chk("t4_bc16", avm.avm_burstcount, 16);
    chk("t4_addr", avm.avm_address, 32'h400);
    chk("t4_wrdy_still_low", bus.bus_wrdy, 0);
    chk("t4_no_pops", 64'(mon_n - base), 0);
    avm.avm_waitrequest = 1'b0;
    wait_beats("t4_beats", base + 16, 100);
    for (int i = 0; i < 16; i++) chk("t4_data", q_data[base+i], 32'h1000 + 32'(i));
    chk("t4_wrdy_back", bus.bus_wrdy, 1);

    // 5: reset during beat 3 of a 4-beat burst
    base = mon_n;
    send_beat(32'h500, 4'd3, 32'h11);
    send_beat(32'h500, 4'd3, 32'h22);
    bus.bus_wval  = 1'b1;
    bus.bus_wdata = 32'h33;
    rst = 1'b1;
    #1;
    chk("t5_wrdy_in_rst", bus.bus_wrdy, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.bus_wval = 1'b0;
    chk("t5_write_low", avm.avm_write, 0);
    chk("t5_idle", idle, 1);
    chk("t5_addr_clr", avm.avm_address, 0);
    chk("t5_bc_clr", avm.avm_burstcount, 0);
    send_beat(32'h600, 4'd1, 32'h55);
    send_beat(32'h600, 4'd1, 32'h66);
    wait_beats("t5_beats", base + 2, 50);
    chk("t5_count", 64'(mon_n - base), 2);
    chk("t5_addr", q_addr[base], 32'h600);
    chk("t5_bc", q_bc[base], 2);
    chk("t5_data0", q_data[base], 32'h55);
    chk("t5_data1", q_data[base+1], 32'h66);

    // 6: streamed 8-beat bursts with random waitrequest, memory image check
    base = mon_n;
    for (int w = 0; w < 256; w++) begin
      exp_img[w] = $urandom;
      got_img[w] = 32'hDEAD_BEEF;
    end
    fork
      begin
        for (int b = 0; b < 32; b++)
          for (int j = 0; j < 8; j++)
            send_beat(32'h2000 + 32'(32 * b), 4'd7, exp_img[b*8+j]);
        tx_done = 1'b1;
      end
      begin
        while (!tx_done) begin
          @(negedge clk);
          avm.avm_waitrequest = ($urandom_range(0, 3) == 0);
        end
        avm.avm_waitrequest = 1'b0;
      end
    join
    wait_beats("t6_beats", base + 256, 3000);
    nb = 0;
    bad_bc = 0;
    for (int k = base; k < mon_n; k++) begin
      if (q_baddr[k] == q_addr[k]) nb++;
      if (q_bc[k] != 5'd8) bad_bc++;
      idx = int'((q_baddr[k] - 32'h2000) >> 2);
      if (q_baddr[k] >= 32'h2000 && idx < 256) got_img[idx] = q_data[k];
      else bad_bc++;
    end
    chk("t6_bursts", 64'(nb), 32);
    chk("t6_bad_beats", 64'(bad_bc), 0);
    for (int w = 0; w < 256; w++) chk("t6_image", got_img[w], exp_img[w]);
    chk("t6_idle", idle, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
